// File: rtl/axi4_types_pkg.sv
// Shared types for the AXI4 write-path arbiter: FSM state, AXI burst/resp
// encodings and the helper that sizes the master-index field.
package axi4_types_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } axi4_arb_state_e;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } axi4_burst_e;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } axi4_resp_e;

    // Width of the master-index field; never narrower than one bit.
    function automatic int axi4_idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/axi4_rr_arb.sv
// Combinational round-robin picker: grants the first requester at or after
// rr_ptr, wrapping modulo N_MST.
module axi4_rr_arb #(
    parameter int N_MST = 2,
    parameter int IDX_W = 1
) (
    input  logic [N_MST-1:0] req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_vld
);

    // Pick the requester with the smallest rotational distance from rr_ptr.
    always_comb begin
        int best;
        int off;
        best    = N_MST;
        off     = 0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        for (int i = 0; i < N_MST; i++) begin
            off = i - int'(rr_ptr);
            if (off < 0) begin
                off = off + N_MST;
            end
            if (req[i] && (off < best)) begin
                best    = off;
                gnt_idx = IDX_W'(i);
                gnt_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi4_wr_arbiter.sv
// Round-robin AXI4 write-channel arbiter: N_MST masters share one AW/W/B
// path. W stays locked to the AW winner until its WLAST; AWID is extended
// with the master index so B can be routed back without any state.
module axi4_wr_arbiter
    import axi4_types_pkg::*;
#(
    parameter int  N_MST  = 2,
    parameter int  ADDR_W = 32,
    parameter int  DATA_W = 64,
    parameter int  ID_W   = 4,
    parameter int  USER_W = 1,
    localparam int STRB_W = DATA_W / 8,
    localparam int IDX_W  = axi4_idx_w(N_MST),
    localparam int SID_W  = ID_W + IDX_W
) (
    input  logic                       aclk,
    input  logic                       areset_n,
    input  logic [N_MST-1:0]           s_awvalid,
    output logic [N_MST-1:0]           s_awready,
    input  logic [N_MST*ID_W-1:0]      s_awid,
    input  logic [N_MST*ADDR_W-1:0]    s_awaddr,
    input  logic [N_MST*8-1:0]         s_awlen,
    input  logic [N_MST*3-1:0]         s_awsize,
    input  logic [N_MST*2-1:0]         s_awburst,
    input  logic [N_MST*USER_W-1:0]    s_awuser,
    input  logic [N_MST-1:0]           s_wvalid,
    input  logic [N_MST-1:0]           s_wlast,
    output logic [N_MST-1:0]           s_wready,
    input  logic [N_MST*DATA_W-1:0]    s_wdata,
    input  logic [N_MST*STRB_W-1:0]    s_wstrb,
    input  logic [N_MST*USER_W-1:0]    s_wuser,
    output logic [N_MST-1:0]           s_bvalid,
    input  logic [N_MST-1:0]           s_bready,
    output logic [N_MST*ID_W-1:0]      s_bid,
    output logic [N_MST*2-1:0]         s_bresp,
    output logic [N_MST*USER_W-1:0]    s_buser,
    output logic                       m_awvalid,
    input  logic                       m_awready,
    output logic [SID_W-1:0]           m_awid,
    output logic [ADDR_W-1:0]          m_awaddr,
    output logic [7:0]                 m_awlen,
    output logic [2:0]                 m_awsize,
    output logic [1:0]                 m_awburst,
    output logic [USER_W-1:0]          m_awuser,
    output logic                       m_wvalid,
    output logic                       m_wlast,
    input  logic                       m_wready,
    output logic [DATA_W-1:0]          m_wdata,
    output logic [STRB_W-1:0]          m_wstrb,
    output logic [USER_W-1:0]          m_wuser,
    input  logic                       m_bvalid,
    output logic                       m_bready,
    input  logic [SID_W-1:0]           m_bid,
    input  logic [1:0]                 m_bresp,
    input  logic [USER_W-1:0]          m_buser,
    output logic                       busy,
    output logic [IDX_W-1:0]           grant_idx,
    output logic                       err_bid
);

    axi4_arb_state_e   state_q, state_d;
    logic [IDX_W-1:0]  grant_q, grant_d;
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic              aw_done_q, aw_done_d;
    logic              w_done_q, w_done_d;
    logic              err_bid_q, err_bid_d;

    logic [IDX_W-1:0]  arb_idx;
    logic              arb_vld;
    logic              in_grant;
    logic [N_MST-1:0]  grant_hit;
    logic [N_MST-1:0]  b_hit;
    logic [IDX_W-1:0]  b_idx;
    logic              b_idx_ok;
    logic              aw_hs;
    logic              wlast_hs;

    logic [ID_W-1:0]   awid_a    [N_MST];
    logic [ADDR_W-1:0] awaddr_a  [N_MST];
    logic [7:0]        awlen_a   [N_MST];
    logic [2:0]        awsize_a  [N_MST];
    logic [1:0]        awburst_a [N_MST];
    logic [USER_W-1:0] awuser_a  [N_MST];
    logic [DATA_W-1:0] wdata_a   [N_MST];
    logic [STRB_W-1:0] wstrb_a   [N_MST];
    logic [USER_W-1:0] wuser_a   [N_MST];

    logic              sel_awvalid, sel_wvalid, sel_wlast;
    logic [ID_W-1:0]   sel_awid;

    axi4_rr_arb #(.N_MST(N_MST), .IDX_W(IDX_W)) u_rr_arb (
        .req     (s_awvalid),
        .rr_ptr  (rr_ptr_q),
        .gnt_idx (arb_idx),
        .gnt_vld (arb_vld)
    );

    assign in_grant = (state_q == ARB_GRANT);
    assign b_idx    = m_bid[SID_W-1:ID_W];

    genvar gi;
    generate
        for (gi = 0; gi < N_MST; gi++) begin : g_mst
            assign awid_a[gi]    = s_awid[gi*ID_W +: ID_W];
            assign awaddr_a[gi]  = s_awaddr[gi*ADDR_W +: ADDR_W];
            assign awlen_a[gi]   = s_awlen[gi*8 +: 8];
            assign awsize_a[gi]  = s_awsize[gi*3 +: 3];
            assign awburst_a[gi] = s_awburst[gi*2 +: 2];
            assign awuser_a[gi]  = s_awuser[gi*USER_W +: USER_W];
            assign wdata_a[gi]   = s_wdata[gi*DATA_W +: DATA_W];
            assign wstrb_a[gi]   = s_wstrb[gi*STRB_W +: STRB_W];
            assign wuser_a[gi]   = s_wuser[gi*USER_W +: USER_W];

            assign grant_hit[gi] = in_grant && (grant_q == IDX_W'(gi));
            assign s_awready[gi] = grant_hit[gi] & m_awready & ~aw_done_q;
            assign s_wready[gi]  = grant_hit[gi] & m_wready & ~w_done_q;

            // B routing is stateless: the upper ID bits name the master.
            assign b_hit[gi]                     = (b_idx == IDX_W'(gi));
            assign s_bvalid[gi]                  = m_bvalid & b_hit[gi];
            assign s_bid[gi*ID_W +: ID_W]        = m_bid[ID_W-1:0];
            assign s_bresp[gi*2 +: 2]            = m_bresp;
            assign s_buser[gi*USER_W +: USER_W]  = m_buser;
        end
    endgenerate

    // Select the granted master's AW/W payload.
    always_comb begin
        sel_awvalid = 1'b0;
        sel_wvalid  = 1'b0;
        sel_wlast   = 1'b0;
        sel_awid    = '0;
        m_awaddr    = '0;
        m_awlen     = '0;
        m_awsize    = '0;
        m_awburst   = '0;
        m_awuser    = '0;
        m_wdata     = '0;
        m_wstrb     = '0;
        m_wuser     = '0;
        for (int i = 0; i < N_MST; i++) begin
            if (grant_q == IDX_W'(i)) begin
                sel_awvalid = s_awvalid[i];
                sel_wvalid  = s_wvalid[i];
                sel_wlast   = s_wlast[i];
                sel_awid    = awid_a[i];
                m_awaddr    = awaddr_a[i];
                m_awlen     = awlen_a[i];
                m_awsize    = awsize_a[i];
                m_awburst   = awburst_a[i];
                m_awuser    = awuser_a[i];
                m_wdata     = wdata_a[i];
                m_wstrb     = wstrb_a[i];
                m_wuser     = wuser_a[i];
            end
        end
    end

    assign m_awvalid = in_grant & ~aw_done_q & sel_awvalid;
    assign m_awid    = {grant_q, sel_awid};
    assign m_wvalid  = in_grant & ~w_done_q & sel_wvalid;
    assign m_wlast   = sel_wlast;
    assign aw_hs     = m_awvalid & m_awready;
    assign wlast_hs  = m_wvalid & m_wready & sel_wlast;

    // Out-of-range indices are swallowed so a bad ID can never stall B.
    assign b_idx_ok  = |b_hit;
    assign m_bready  = b_idx_ok ? |(s_bready & b_hit) : 1'b1;

    // Next-state: arbitrate in IDLE, leave GRANT once both AW and WLAST are done.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_ptr_d  = rr_ptr_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        err_bid_d = err_bid_q | (m_bvalid & ~b_idx_ok);
        case (state_q)
            ARB_IDLE: begin
                if (arb_vld) begin
                    state_d   = ARB_GRANT;
                    grant_d   = arb_idx;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            ARB_GRANT: begin
                aw_done_d = aw_done_q | aw_hs;
                w_done_d  = w_done_q | wlast_hs;
                if (aw_done_d && w_done_d) begin
                    state_d   = ARB_IDLE;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    rr_ptr_d  = (grant_q == IDX_W'(N_MST-1)) ? '0 : grant_q + IDX_W'(1);
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // State registers; reset abandons any burst in flight.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            state_q   <= ARB_IDLE;
            grant_q   <= '0;
            rr_ptr_q  <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            err_bid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_ptr_q  <= rr_ptr_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            err_bid_q <= err_bid_d;
        end
    end

    assign busy      = in_grant;
    assign grant_idx = grant_q;
    assign err_bid   = err_bid_q;

endmodule

// File: tb/tb_axi4_wr_arbiter.sv
// Scoreboard bench for axi4_wr_arbiter: stimulus pushes expected AW/W/B
// transfers, a negedge monitor pops and compares on each DUT handshake.
module tb_axi4_wr_arbiter;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 64;
    localparam int IW = 4;
    localparam int SW = 5;

    logic aclk;
    logic areset_n;

    logic [N-1:0]    s_awvalid, s_awready, s_wvalid, s_wlast, s_wready;
    logic [N-1:0]    s_bvalid, s_bready, s_awuser, s_wuser, s_buser;
    logic [N*IW-1:0] s_awid, s_bid;
    logic [N*AW-1:0] s_awaddr;
    logic [N*8-1:0]  s_awlen, s_wstrb;
    logic [N*3-1:0]  s_awsize;
    logic [N*2-1:0]  s_awburst, s_bresp;
    logic [N*DW-1:0] s_wdata;
    logic            m_awvalid, m_awready, m_wvalid, m_wlast, m_wready;
    logic            m_bvalid, m_bready, busy, err_bid;
    logic [SW-1:0]   m_awid, m_bid;
    logic [AW-1:0]   m_awaddr;
    logic [7:0]      m_awlen, m_wstrb;
    logic [2:0]      m_awsize;
    logic [1:0]      m_awburst, m_bresp;
    logic [0:0]      m_awuser, m_wuser, m_buser, grant_idx;
    logic [DW-1:0]   m_wdata;

    // Second instance (three masters) for the out-of-range B index case.
    logic [2:0]    d3_s_awready, d3_s_wready, d3_s_bvalid, d3_s_bready, d3_s_buser;
    logic [11:0]   d3_s_bid;
    logic [5:0]    d3_s_bresp, d3_m_awid, d3_m_bid;
    logic          d3_m_awvalid, d3_m_wvalid, d3_m_wlast, d3_m_bvalid, d3_m_bready;
    logic          d3_busy, d3_err_bid;
    logic [1:0]    d3_grant_idx, d3_m_awburst;
    logic [AW-1:0] d3_m_awaddr;
    logic [7:0]    d3_m_awlen, d3_m_wstrb;
    logic [2:0]    d3_m_awsize;
    logic [0:0]    d3_m_awuser, d3_m_wuser;
    logic [DW-1:0] d3_m_wdata;

    int n_checks = 0;
    int n_fail   = 0;

    logic [44:0] exp_aw [$];   // {awid, awaddr, awlen}
    logic [64:0] exp_w  [$];   // {wlast, wdata}
    logic [14:0] exp_b  [$];   // {s_bvalid, s_bid, s_bresp, m_bready}

    axi4_wr_arbiter #(.N_MST(2), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW), .USER_W(1)) dut (
        .aclk(aclk), .areset_n(areset_n),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awid(s_awid), .s_awaddr(s_awaddr),
        .s_awlen(s_awlen), .s_awsize(s_awsize), .s_awburst(s_awburst), .s_awuser(s_awuser),
        .s_wvalid(s_wvalid), .s_wlast(s_wlast), .s_wready(s_wready), .s_wdata(s_wdata),
        .s_wstrb(s_wstrb), .s_wuser(s_wuser),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bid(s_bid), .s_bresp(s_bresp), .s_buser(s_buser),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awid(m_awid), .m_awaddr(m_awaddr),
        .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst), .m_awuser(m_awuser),
        .m_wvalid(m_wvalid), .m_wlast(m_wlast), .m_wready(m_wready), .m_wdata(m_wdata),
        .m_wstrb(m_wstrb), .m_wuser(m_wuser),
        .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bid(m_bid), .m_bresp(m_bresp), .m_buser(m_buser),
        .busy(busy), .grant_idx(grant_idx), .err_bid(err_bid)
    );

    axi4_wr_arbiter #(.N_MST(3), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW), .USER_W(1)) dut3 (
        .aclk(aclk), .areset_n(areset_n),
        .s_awvalid(3'b000), .s_awready(d3_s_awready), .s_awid(12'h0), .s_awaddr({3*AW{1'b0}}),
        .s_awlen(24'h0), .s_awsize(9'h0), .s_awburst(6'h0), .s_awuser(3'b000),
        .s_wvalid(3'b000), .s_wlast(3'b000), .s_wready(d3_s_wready), .s_wdata({3*DW{1'b0}}),
        .s_wstrb(24'h0), .s_wuser(3'b000),
        .s_bvalid(d3_s_bvalid), .s_bready(d3_s_bready), .s_bid(d3_s_bid), .s_bresp(d3_s_bresp),
        .s_buser(d3_s_buser),
        .m_awvalid(d3_m_awvalid), .m_awready(1'b1), .m_awid(d3_m_awid), .m_awaddr(d3_m_awaddr),
        .m_awlen(d3_m_awlen), .m_awsize(d3_m_awsize), .m_awburst(d3_m_awburst), .m_awuser(d3_m_awuser),
        .m_wvalid(d3_m_wvalid), .m_wlast(d3_m_wlast), .m_wready(1'b1), .m_wdata(d3_m_wdata),
        .m_wstrb(d3_m_wstrb), .m_wuser(d3_m_wuser),
        .m_bvalid(d3_m_bvalid), .m_bready(d3_m_bready), .m_bid(d3_m_bid), .m_bresp(2'b00),
        .m_buser(1'b0),
        .busy(d3_busy), .grant_idx(d3_grant_idx), .err_bid(d3_err_bid)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // Monitor: every handshake / B presentation pops one expected entry.
    always @(negedge aclk) begin
        if (areset_n) begin
            if (m_awvalid && m_awready) begin
                if (exp_aw.size() == 0) check("aw_unexpected", {m_awid, m_awaddr, m_awlen}, 0);
                else check("aw_xfer", {m_awid, m_awaddr, m_awlen}, exp_aw.pop_front());
            end
            if (m_wvalid && m_wready) begin
                if (exp_w.size() == 0) check("w_unexpected", {m_wlast, m_wdata}, 0);
                else check("w_beat", {m_wlast, m_wdata}, exp_w.pop_front());
            end
            if (m_bvalid) begin
                if (exp_b.size() == 0) check("b_unexpected", {s_bvalid, s_bid, s_bresp, m_bready}, 0);
                else check("b_route", {s_bvalid, s_bid, s_bresp, m_bready}, exp_b.pop_front());
            end
        end
    end

    task automatic apply_reset();
        areset_n  = 1'b0;
        s_awvalid = '0; s_awid = '0; s_awaddr = '0; s_awlen = '0; s_awsize = '0;
        s_awburst = '0; s_awuser = '0; s_wvalid = '0; s_wlast = '0; s_wdata = '0;
        s_wstrb = '0; s_wuser = '0; s_bready = '0;
        m_awready = 1'b1; m_wready = 1'b1; m_bvalid = 1'b0; m_bid = '0; m_bresp = '0; m_buser = '0;
        d3_s_bready = '0; d3_m_bvalid = 1'b0; d3_m_bid = '0;
        repeat (2) @(posedge aclk);
        #1 areset_n = 1'b1;
    endtask

    task automatic push_burst(input int m, input logic [3:0] id, input logic [31:0] addr,
                              input logic [7:0] len, input logic [63:0] base);
        logic [0:0] mi;
        mi = m[0:0];
        exp_aw.push_back({mi, id, addr, len});
        for (int b = 0; b <= int'(len); b++) begin
            exp_w.push_back({(b == int'(len)), base + 64'(b)});
        end
    endtask

    task automatic do_aw(input int m, input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
        logic rdy;
        int n;
        s_awvalid[m] = 1'b1;
        s_awid[m*IW +: IW] = id;
        s_awaddr[m*AW +: AW] = addr;
        s_awlen[m*8 +: 8] = len;
        s_awsize[m*3 +: 3] = 3'd3;
        s_awburst[m*2 +: 2] = 2'b01;
        rdy = 1'b0; n = 0;
        while (!rdy && n < 200) begin
            @(negedge aclk); rdy = s_awready[m];
            @(posedge aclk); #1; n++;
        end
        check("aw_handshake", rdy, 1'b1);
        s_awvalid[m] = 1'b0;
    endtask

    task automatic do_w(input int m, input int nbeats, input logic [63:0] base);
        logic rdy;
        int n;
        for (int b = 0; b < nbeats; b++) begin
            s_wvalid[m] = 1'b1;
            s_wlast[m] = (b == nbeats - 1);
            s_wdata[m*DW +: DW] = base + 64'(b);
            s_wstrb[m*8 +: 8] = 8'hFF;
            rdy = 1'b0; n = 0;
            while (!rdy && n < 200) begin
                @(negedge aclk); rdy = s_wready[m];
                @(posedge aclk); #1; n++;
            end
            check("w_handshake", rdy, 1'b1);
        end
        s_wvalid[m] = 1'b0;
        s_wlast[m] = 1'b0;
    endtask

    task automatic wait_busy(input logic val);
        int n;
        n = 0;
        @(negedge aclk);
        while (busy !== val && n < 200) begin
            @(negedge aclk); n++;
        end
        check("busy_reach", busy, val);
    endtask

    initial begin
        // Reset state
        apply_reset();
        check("rst_busy", busy, 1'b0);
        check("rst_grant_idx", grant_idx, 1'b0);
        check("rst_valids", {m_awvalid, m_wvalid, m_bready, s_bvalid}, 0);
        check("rst_readies", {s_awready, s_wready}, 0);
        check("rst_err_bid", err_bid, 1'b0);

        // Single master, AWLEN=3
        push_burst(0, 4'h5, 32'h0000_1000, 8'd3, 64'h1111_0000_0000_0000);
        fork
            do_aw(0, 4'h5, 32'h0000_1000, 8'd3);
            do_w(0, 4, 64'h1111_0000_0000_0000);
            begin
                @(negedge aclk); check("t1_latency_idle", m_awvalid, 1'b0);
                @(negedge aclk); check("t1_latency_aw", m_awvalid, 1'b1);
                check("t1_busy", busy, 1'b1);
            end
        join
        @(negedge aclk); check("t1_busy_after_wlast", busy, 1'b0);

        // Contention: both masters at once
        apply_reset();
        push_burst(0, 4'hA, 32'h0000_2000, 8'd1, 64'h2222_0000_0000_0000);
        push_burst(1, 4'hB, 32'h0000_3000, 8'd1, 64'h3333_0000_0000_0000);
        fork
            do_aw(0, 4'hA, 32'h0000_2000, 8'd1);
            do_w(0, 2, 64'h2222_0000_0000_0000);
            do_aw(1, 4'hB, 32'h0000_3000, 8'd1);
            do_w(1, 2, 64'h3333_0000_0000_0000);
            begin
                wait_busy(1'b1); check("t2_first_grant", grant_idx, 1'b0);
                wait_busy(1'b0);
                wait_busy(1'b1); check("t2_second_grant", grant_idx, 1'b1);
            end
        join

        // W completes before AW
        apply_reset();
        m_awready = 1'b0;
        push_burst(1, 4'h6, 32'h0000_4000, 8'd1, 64'h4444_0000_0000_0000);
        fork
            do_aw(1, 4'h6, 32'h0000_4000, 8'd1);
            do_w(1, 2, 64'h4444_0000_0000_0000);
            begin
                repeat (5) @(posedge aclk);
                #1;
                check("t3_grant_held", busy, 1'b1);
                check("t3_w_closed", {m_wvalid, s_wready}, 0);
                m_awready = 1'b1;
            end
        join
        @(negedge aclk); check("t3_idle_after_aw", busy, 1'b0);

        // B routing
        @(posedge aclk); #1;
        m_bvalid = 1'b1; m_bid = 5'b1_0011; m_bresp = 2'b10; s_bready = 2'b01;
        exp_b.push_back({2'b10, 8'h33, 4'b1010, 1'b0});
        @(posedge aclk); #1;
        s_bready = 2'b10;
        exp_b.push_back({2'b10, 8'h33, 4'b1010, 1'b1});
        @(posedge aclk); #1;
        m_bid = 5'b0_1010; m_bresp = 2'b00; s_bready = 2'b01;
        exp_b.push_back({2'b01, 8'hAA, 4'b0000, 1'b1});
        @(posedge aclk); #1;
        m_bvalid = 1'b0; m_bid = '0; s_bready = 2'b00;
        check("t4_err_bid", err_bid, 1'b0);

        // Master 0 burst so the pointer moves to master 1
        push_burst(0, 4'h1, 32'h0000_5000, 8'd0, 64'h5555_0000_0000_0000);
        fork
            do_aw(0, 4'h1, 32'h0000_5000, 8'd0);
            do_w(0, 1, 64'h5555_0000_0000_0000);
        join

        // Reset after 2 of 4 beats
        exp_aw.push_back({1'b0, 4'h2, 32'h0000_6000, 8'd3});
        exp_w.push_back({1'b0, 64'h6666_0000_0000_0000});
        exp_w.push_back({1'b0, 64'h6666_0000_0000_0001});
        s_awvalid[0] = 1'b1; s_awid[3:0] = 4'h2; s_awaddr[31:0] = 32'h0000_6000; s_awlen[7:0] = 8'd3;
        s_wvalid[0] = 1'b1; s_wlast[0] = 1'b0; s_wdata[63:0] = 64'h6666_0000_0000_0000;
        @(posedge aclk);
        @(posedge aclk); #1;
        s_awvalid[0] = 1'b0; s_wdata[63:0] = 64'h6666_0000_0000_0001;
        @(posedge aclk); #1;
        s_wdata[63:0] = 64'h6666_0000_0000_0002;
        #1 areset_n = 1'b0;
        #1;
        check("t6_rst_valids", {m_awvalid, m_wvalid}, 0);
        check("t6_rst_readies", {s_awready, s_wready}, 0);
        check("t6_rst_busy", busy, 1'b0);
        apply_reset();
        push_burst(0, 4'h7, 32'h0000_7000, 8'd0, 64'h7777_0000_0000_0000);
        push_burst(1, 4'h8, 32'h0000_8000, 8'd0, 64'h8888_0000_0000_0000);
        fork
            do_aw(0, 4'h7, 32'h0000_7000, 8'd0);
            do_w(0, 1, 64'h7777_0000_0000_0000);
            do_aw(1, 4'h8, 32'h0000_8000, 8'd0);
            do_w(1, 1, 64'h8888_0000_0000_0000);
            begin
                wait_busy(1'b1); check("t7_first_after_reset", grant_idx, 1'b0);
            end
        join

        // Out-of-range B index on the three-master instance
        @(posedge aclk); #1;
        d3_m_bvalid = 1'b1; d3_m_bid = {2'd3, 4'h7}; d3_s_bready = 3'b000;
        #1;
        check("t5_bad_drop_ready", d3_m_bready, 1'b1);
        check("t5_bad_no_valid", d3_s_bvalid, 3'b000);
        check("t5_err_before", d3_err_bid, 1'b0);
        @(posedge aclk); #1;
        d3_m_bvalid = 1'b0;
        check("t5_err_set", d3_err_bid, 1'b1);
        repeat (3) @(posedge aclk);
        #1;
        check("t5_err_sticky", d3_err_bid, 1'b1);
        d3_m_bvalid = 1'b1; d3_m_bid = {2'd2, 4'h1}; d3_s_bready = 3'b011;
        #1;
        check("t5_idx2_valid", d3_s_bvalid, 3'b100);
        check("t5_idx2_ready", d3_m_bready, 1'b0);
        d3_m_bvalid = 1'b0;

        @(negedge aclk);
        check("aw_queue_drained", exp_aw.size(), 0);
        check("w_queue_drained", exp_w.size(), 0);
        check("b_queue_drained", exp_b.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axi4_wr_arbiter.md
# axi4_wr_arbiter

Round-robin arbiter that shares one AXI4 write-address/data/response path (AW, W, B) between `N_MST` requesting masters and one downstream slave port. It locks W to the master granted on AW until that burst's WLAST handshake, and extends AWID with the master index. B responses are routed back by that index. It sits between multiple VIP/DUT masters and a single `axi4_if` slave-side instance.

## Interface
- `N_MST`, 2, number of masters (2..8)
- `ADDR_W`, 32, address width
- `DATA_W`, 64, data width; `STRB_W = DATA_W/8`
- `ID_W`, 4, master-side ID width
- `USER_W`, 1, user width on AW/W/B
- `IDX_W`, derived `$clog2(N_MST)`; slave-side ID width `SID_W = ID_W+IDX_W`
- `aclk  in  1  clock`
- `areset_n  in  1  asynchronous active-low reset`
- `s_aw{valid,ready}  in/out  N_MST each  per-master AW handshake`
- `s_aw{id,addr,len,size,burst,user}  in  N_MST×{ID_W,ADDR_W,8,3,2,USER_W}  packed per-master AW payload, master i at slice i`
- `s_w{valid,last} in N_MST; s_wready out N_MST; s_w{data,strb,user} in N_MST×{DATA_W,STRB_W,USER_W}`
- `s_b{valid} out N_MST; s_bready in N_MST; s_b{id,resp,user} out N_MST×{ID_W,2,USER_W}`
- `m_aw{valid} out 1; m_awready in 1; m_aw{id,addr,len,size,burst,user} out {SID_W,ADDR_W,8,3,2,USER_W}`
- `m_w{valid,last} out 1; m_wready in 1; m_w{data,strb,user} out {DATA_W,STRB_W,USER_W}`
- `m_bvalid in 1; m_bready out 1; m_b{id,resp,user} in {SID_W,2,USER_W}`
- `busy  out  1  grant held`
- `grant_idx  out  IDX_W  current/last granted master`
- `err_bid  out  1  sticky: B received with index ≥ N_MST`

## Operation
- FSM: IDLE, GRANT. Two flags in GRANT: `aw_done`, `w_done`.
- IDLE: if any `s_awvalid`, pick the first requester at or after `rr_ptr`, wrapping modulo N_MST. Register `grant_idx`, clear flags, go to GRANT. No request: stay IDLE.
- GRANT, AW: `m_aw*` is the combinational mux of master `grant_idx`, qualified by `!aw_done`. `m_awid = {grant_idx, s_awid[g]}`. `s_awready[g] = m_awready & !aw_done`. Handshake sets `aw_done`.
- GRANT, W: `m_w*` is the mux of master g, qualified by `!w_done`. `s_wready[g] = m_wready & !w_done`. A handshake with `wlast` sets `w_done`. W may complete before AW; both orders are legal.
- GRANT exits to IDLE in the cycle both flags are set, counting same-cycle handshakes. On exit, `rr_ptr = (g+1) mod N_MST`.
- Non-granted masters see `s_awready=0` and `s_wready=0`.
- B: `s_bvalid[i] = m_bvalid & (m_bid[SID_W-1:ID_W]==i)`. `s_bid = m_bid[ID_W-1:0]`; resp/user are broadcast. `m_bready = s_bready[idx]`.
- B with idx ≥ N_MST: `m_bready=1` (drop) and set `err_bid`. `err_bid` is cleared only by reset.
- B is independent of the FSM. It is never blocked by AW/W arbitration.

## Timing
- Reset values: FSM IDLE, `rr_ptr=0`, `grant_idx=0`, `busy=0`, `err_bid=0`, all `*valid`/`*ready` outputs 0 (B outputs 0 because `m_bvalid` is 0).
- Arbitration latency: `m_awvalid` rises 1 cycle after `s_awvalid` is first seen in IDLE.
- One idle bubble cycle between bursts (IDLE re-arbitrates).
- Payload passes combinationally during GRANT; there is no pipeline register on AW/W/B.
- Master drops AWVALID before handshake (protocol violation): grant is held; the arbiter does not time out.
- Reset asserted mid-burst: immediate return to reset values. Outstanding bursts are abandoned.

## Structure
- Shared package `axi4_types_pkg`: arbiter state enum `axi4_arb_state_e`, the burst/resp typedefs, and the `IDX_W` helper function.
- Sub-module `axi4_rr_arb`: parameterised round-robin picker. Inputs are the request vector and `rr_ptr`; outputs are `gnt_idx` and `gnt_vld`. It is combinational.
- The top holds the FSM, flags, muxes and B demux.

## Test plan
- Single master: N_MST=2, master 0 issues AWLEN=3 with 4 W beats. Required: `m_awid={1'b0,id}`, 4 beats pass, `busy` low 1 cycle after WLAST.
- Contention: both masters assert AWVALID in the same cycle after reset. Required: master 0 granted first, master 1 second (`grant_idx` 0→1), and W beats are never interleaved.
- W before AW: master 1 sends all W beats (WLAST) while `m_awready=0` for 5 cycles. Required: GRANT is held until the AW handshake, then IDLE.
- B routing: slave returns `m_bid=5'b1_0011`. Required: `s_bvalid[1]=1`, `s_bid=4'h3`, `s_bvalid[0]=0`, and `m_bready` follows `s_bready[1]`.
- Bad index: N_MST=3, `m_bid` index 3. Required: B is dropped (`m_bready=1`), `err_bid` goes to 1 and stays 1.
- Reset mid-burst: drop `areset_n` after 2 of 4 beats. Required: all valids/readies are 0 immediately, and the next arbitration starts at master 0.
